syscall_disp_hist: RTL and testbench
====================================

Name: syscall_disp_hist

Overview:
Syscall display unit with history for the pipelined CPU FPGA top.
- Captures the print-value operand (RF_B) of each non-halt syscall into a circular history buffer of DEPTH entries.
- Drives a registered display word selectable by age, plus a sticky halt flag and a syscall counter.
- Sits beside the register-file read stage.
- Successor of the single-register syscall latch: adds depth, age selection, stall qualification, halt detection and counting.

Parameters:
DATA_W, 32, width of RF_A/RF_B and display word
DEPTH, 8, history entries; power of two, >=2
HALT_CODE, 10, RF_A value that means exit/halt syscall
CNT_W, 16, width of syscall event counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
syscall  in  1  syscall instruction at this stage
stall  in  1  pipeline stall; syscall ignored while 1
rf_a  in  DATA_W  service code ($v0)
rf_b  in  DATA_W  print operand ($a0)
view_sel  in  log2(DEPTH)  age select: 0 = newest, k = k-th older
syscallout  out  DATA_W  registered display word
halted  out  1  sticky, set by halt syscall
valid_cnt  out  log2(DEPTH)+1  number of valid history entries
sys_cnt  out  CNT_W  count of accepted print syscalls

Behaviour:
- Reset: rst==0 sampled at a rising edge clears wr_ptr, valid_cnt, sys_cnt, halted and syscallout to 0.
  - Reset has priority over every other input, including syscall in the same cycle.
  - Memory contents are not cleared; they are unreachable while valid_cnt==0.
- Accepted event: ev = syscall & ~stall & ~halted.
- Halt: on ev with rf_a==HALT_CODE, set halted<=1. No push, no count change. halted stays 1 until reset; afterwards every syscall is ignored.
- Push: on ev with rf_a!=HALT_CODE:
  - mem[wr_ptr]<=rf_b.
  - wr_ptr<=wr_ptr+1 modulo DEPTH (natural wrap).
  - valid_cnt<=min(valid_cnt+1, DEPTH).
  - sys_cnt<=sys_cnt+1, saturating at all-ones.
- Entry lookup: entry(k) = mem[(wr_ptr-1-k) mod DEPTH], evaluated on the post-update buffer.
- Display: every edge (not in reset), syscallout <= entry(view_sel) of the post-update buffer.
  - A push at edge N is visible with view_sel==0 immediately after edge N (zero added latency, same as the old latch).
  - On a push edge with view_sel==0, drive rf_b directly; with view_sel=k>0, drive the pre-update entry(k-1).
  - If view_sel >= post-update valid_cnt, syscallout<=0.
  - Changing view_sel alone updates syscallout at the next edge (1-cycle latency).
- Overflow: when valid_cnt==DEPTH a push overwrites the oldest entry. No error flag.
- stall==1 freezes the buffer, counters and halted. The display keeps tracking view_sel.
- Arithmetic: pointer math is unsigned log2(DEPTH) bits with natural wrap. No X propagation from unwritten memory: guarded by the valid_cnt check.
- Only one event per cycle; no read/write port conflict beyond the bypass rule above.

Test Plan:
1. Hold rst=0 two cycles with syscall=1, rf_a=1, rf_b=5 -> syscallout=0, valid_cnt=0, sys_cnt=0, halted=0.
2. rst=1, view_sel=0; push rf_b=0x11,0x22,0x33 (rf_a=1) on consecutive cycles -> syscallout 0x11,0x22,0x33 right after each edge. Then view_sel=2 -> 0x11 next edge; view_sel=3 -> 0; valid_cnt=3, sys_cnt=3.
3. With DEPTH=8, push 10 values 1..10 -> valid_cnt=8. view_sel=0 gives 10, view_sel=7 gives 3; wr_ptr wrapped to 2.
4. syscall=1 with stall=1, rf_b=0xAA -> no change to the buffer, sys_cnt or display.
5. Push 0x55, then rf_a=10 with rf_b=0x99 -> halted=1, syscallout stays 0x55, sys_cnt unchanged. A further push of 0x77 is ignored.
6. Mid-stream reset with syscall=1, rf_a=10 in the same cycle -> all outputs 0, halted=0. After release, push 0x1 -> syscallout=0x1, valid_cnt=1.

Source files
------------

// File: rtl/syscall_disp_hist_if.sv
// Syscall display bus: pipeline-side syscall request plus the display/status outputs.
// Parameters must match those of the syscall_disp_hist instance it connects to.
interface syscall_disp_hist_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              syscall;
  logic              stall;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [AW-1:0]     view_sel;
  logic [DATA_W-1:0] syscallout;
  logic              halted;
  logic [AW:0]       valid_cnt;
  logic [CNT_W-1:0]  sys_cnt;

  modport master (
    output syscall, stall, rf_a, rf_b, view_sel,
    input  syscallout, halted, valid_cnt, sys_cnt
  );

  modport slave (
    input  syscall, stall, rf_a, rf_b, view_sel,
    output syscallout, halted, valid_cnt, sys_cnt
  );
endinterface

// File: rtl/syscall_disp_hist.sv
// Syscall display with a circular history of print operands, age-selectable display,
// sticky halt flag and saturating syscall counter. A push is visible at view 0 on the same edge.
module syscall_disp_hist #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int HALT_CODE = 10,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  syscall_disp_hist_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] HALT_V  = DATA_W'(HALT_CODE);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       valid_cnt_q, valid_cnt_d;
  logic [CNT_W-1:0]  sys_cnt_q, sys_cnt_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] syscallout_q, syscallout_d;

  logic              ev;
  logic              push;
  logic [AW-1:0]     rd_idx;

  assign ev   = bus.syscall & ~bus.stall & ~halted_q;
  assign push = ev & (bus.rf_a != HALT_V);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    valid_cnt_d  = valid_cnt_q;
    sys_cnt_d    = sys_cnt_q;
    halted_d     = halted_q;
    syscallout_d = '0;

    if (ev && (bus.rf_a == HALT_V)) begin
      halted_d = 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (valid_cnt_q != DEPTH_V) valid_cnt_d = valid_cnt_q + (AW+1)'(1);
      if (sys_cnt_q != '1)        sys_cnt_d   = sys_cnt_q + CNT_W'(1);
    end

    // On a push the post-update entry(k) is the pre-update entry(k-1), i.e. one slot closer
    // to wr_ptr_q; entry(0) is taken straight from rf_b since memory is not yet written.
    rd_idx = wr_ptr_q - bus.view_sel - (push ? AW'(0) : AW'(1));
    if ({1'b0, bus.view_sel} < valid_cnt_d) begin
      if (push && (bus.view_sel == '0)) syscallout_d = bus.rf_b;
      else                              syscallout_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      valid_cnt_q  <= '0;
      sys_cnt_q    <= '0;
      halted_q     <= 1'b0;
      syscallout_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      valid_cnt_q  <= valid_cnt_d;
      sys_cnt_q    <= sys_cnt_d;
      halted_q     <= halted_d;
      syscallout_q <= syscallout_d;
    end
  end

  // History storage is never cleared; valid_cnt_q guards every read.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= bus.rf_b;
  end

  assign bus.syscallout = syscallout_q;
  assign bus.halted     = halted_q;
  assign bus.valid_cnt  = valid_cnt_q;
  assign bus.sys_cnt    = sys_cnt_q;
endmodule

// File: tb/tb_syscall_disp_hist.sv
// Scoreboard bench for syscall_disp_hist: a history-queue model predicts each edge's outputs.
module tb_syscall_disp_hist;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(DEPTH);

  typedef struct {
    logic [DATA_W-1:0] disp;
    logic              halted;
    logic [AW:0]       vcnt;
    logic [CNT_W-1:0]  scnt;
    logic [AW-1:0]     ptr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  syscall_disp_hist_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  syscall_disp_hist #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HALT_CODE(10), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] hist[$];
  logic              m_halted;
  int                m_cnt;
  int                m_ptr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic r, input logic sc, input logic st,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input int vs, input string tag);
    exp_t e;
    exp_t got;
    rst          = r;
    bus.syscall  = sc;
    bus.stall    = st;
    bus.rf_a     = a;
    bus.rf_b     = b;
    bus.view_sel = AW'(vs);
    if (!r) begin
      hist.delete();
      m_halted = 1'b0;
      m_cnt    = 0;
      m_ptr    = 0;
      e.disp   = '0;
    end else begin
      if (sc && !st && !m_halted) begin
        if (a == 10) m_halted = 1'b1;
        else begin
          hist.push_front(b);
          if (hist.size() > DEPTH) void'(hist.pop_back());
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      e.disp = (vs < hist.size()) ? hist[vs] : '0;
    end
    e.halted = m_halted;
    e.vcnt   = (AW+1)'(hist.size());
    e.scnt   = CNT_W'(m_cnt);
    e.ptr    = AW'(m_ptr);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".syscallout"}, 64'(bus.syscallout), 64'(got.disp));
    chk({tag, ".halted"},     64'(bus.halted),     64'(got.halted));
    chk({tag, ".valid_cnt"},  64'(bus.valid_cnt),  64'(got.vcnt));
    chk({tag, ".sys_cnt"},    64'(bus.sys_cnt),    64'(got.scnt));
    chk({tag, ".wr_ptr"},     64'(dut.wr_ptr_q),   64'(got.ptr));
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    m_halted = 1'b0;
    m_cnt    = 0;
    m_ptr    = 0;
    rst = 1'b0; bus.syscall = 1'b0; bus.stall = 1'b0;
    bus.rf_a = '0; bus.rf_b = '0; bus.view_sel = '0;
    #2;

    // Reset dominates a concurrent syscall.
    step(0, 1, 0, 1, 5, 0, "rst0");
    step(0, 1, 0, 1, 5, 0, "rst1");

    // Consecutive pushes visible at view 0 on their own edge; then age selection.
    step(1, 1, 0, 1, 32'h11, 0, "push11");
    step(1, 1, 0, 1, 32'h22, 0, "push22");
    step(1, 1, 0, 1, 32'h33, 0, "push33");
    step(1, 0, 0, 1, 0, 2, "view2");
    step(1, 0, 0, 1, 0, 3, "view3_empty");

    // Overflow: ten more pushes wrap the buffer; oldest entries are overwritten.
    for (int i = 1; i <= 10; i++) step(1, 1, 0, 1, i, 0, "wrap");
    step(1, 0, 0, 1, 0, 7, "wrap_oldest");
    step(1, 0, 0, 1, 0, 0, "wrap_newest");

    // Push while viewing an older entry exercises the shifted read.
    step(1, 1, 0, 1, 32'hB0, 3, "push_view3");
    step(1, 1, 0, 1, 32'hB1, 7, "push_view7");

    // Stall freezes state while the display still follows view_sel.
    step(1, 1, 1, 1, 32'hAA, 0, "stall_v0");
    step(1, 1, 1, 1, 32'hAA, 1, "stall_v1");

    // Mixed random traffic (no halt codes).
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1, v, $urandom_range(0, DEPTH - 1), "rand");
    end

    // Halt: no push, no count change, later syscalls ignored.
    step(1, 1, 0, 1, 32'h55, 0, "push55");
    step(1, 1, 0, 10, 32'h99, 0, "halt");
    step(1, 1, 0, 1, 32'h77, 0, "after_halt");
    step(1, 1, 0, 10, 32'h78, 1, "after_halt_v1");

    // Mid-stream reset with a halt syscall present, then a fresh push.
    step(0, 1, 0, 10, 32'h99, 0, "mid_rst");
    step(1, 1, 0, 1, 32'h1, 0, "post_rst_push");
    step(1, 0, 0, 1, 0, 1, "post_rst_v1");

    if (sb_q.size() != 0) chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
